// File: rtl/pattern_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out.
// A one-word holding buffer lets consecutive words stream with no idle cycle between them.
module pattern_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             d_out,
    output logic             valid_out,
    output logic             last_out
);
    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
    localparam int             OUT_BIT  = MSB_FIRST ? WIDTH - 1 : 0;

    logic [WIDTH-1:0] shift_reg, shift_next, shifted;
    logic [CW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic             active_reg, active_next;
    logic [WIDTH-1:0] hold_reg, hold_next;
    logic             hold_full_reg, hold_full_next;
    logic             load_slot, accept, at_last;

    // Shifter contents after moving one place toward the output end.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign shifted[gi] = 1'b0;
                end else begin : g_move
                    assign shifted[gi] = shift_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_fill
                    assign shifted[gi] = 1'b0;
                end else begin : g_move
                    assign shifted[gi] = shift_reg[gi+1];
                end
            end
        end
    endgenerate

    assign at_last    = active_reg && (bit_cnt_reg == LAST_CNT);
    assign load_slot  = !active_reg || at_last;
    assign data_ready = rst && !hold_full_reg;
    assign accept     = data_valid && data_ready;

    always_comb begin
        shift_next     = shift_reg;
        bit_cnt_next   = bit_cnt_reg;
        active_next    = active_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        if (load_slot) begin
            bit_cnt_next = '0;
            // A buffered word always wins the slot; data_ready was low so nothing new arrives.
            if (hold_full_reg) begin
                shift_next     = hold_reg;
                hold_full_next = 1'b0;
                active_next    = 1'b1;
            end else if (accept) begin
                shift_next  = data_in;
                active_next = 1'b1;
            end else begin
                active_next = 1'b0;
            end
        end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            shift_next   = shifted;
            if (accept) begin
                hold_next      = data_in;
                hold_full_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            active_reg    <= 1'b0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
        end else begin
            shift_reg     <= shift_next;
            bit_cnt_reg   <= bit_cnt_next;
            active_reg    <= active_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
        end
    end

    assign d_out     = active_reg && shift_reg[OUT_BIT];
    assign valid_out = active_reg;
    assign last_out  = at_last;
endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench for pattern_serializer: table vectors, hand sequences and a
// random run against a bit-queue reference model of the serial stream.
module tb_pattern_serializer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0] data_in;
    logic         data_valid, data_ready, d_out, valid_out, last_out;
    logic [W-1:0] lsb_data_in;
    logic         lsb_data_valid, lsb_data_ready, lsb_d_out, lsb_valid_out, lsb_last_out;

    pattern_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .d_out(d_out), .valid_out(valid_out), .last_out(last_out)
    );

    pattern_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst_n), .data_in(lsb_data_in), .data_valid(lsb_data_valid),
        .data_ready(lsb_data_ready), .d_out(lsb_d_out), .valid_out(lsb_valid_out),
        .last_out(lsb_last_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: bits still to appear on d_out (front = bit shown this cycle).
    bit exp_q[$];
    bit last_q[$];
    bit model_ready = 1'b0;
    bit last_acc = 1'b0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the main DUT: drive at negedge, update model at posedge, check at next negedge.
    task automatic cycle(input logic dv, input logic [W-1:0] din);
        bit acc;
        data_valid = dv;
        data_in    = din;
        acc = dv && model_ready;
        @(posedge clk);
        if (acc) begin
            for (int i = 0; i < W; i++) begin
                exp_q.push_back(din[W-1-i]);
                last_q.push_back(i == W - 1);
            end
        end
        @(negedge clk);
        chk("valid_out", valid_out, exp_q.size() > 0);
        chk("d_out", d_out, (exp_q.size() > 0) ? exp_q[0] : 1'b0);
        chk("last_out", last_out, (exp_q.size() > 0) ? last_q[0] : 1'b0);
        // A buffered word exists exactly when more than one word's worth of bits is pending.
        model_ready = (exp_q.size() <= W);
        chk("data_ready", data_ready, model_ready);
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(last_q.pop_front());
        end
        last_acc = acc;
    endtask

    typedef struct {
        logic         dv;
        logic [W-1:0] din;
        logic         ev;
        logic         ed;
        logic         el;
        logic         er;
    } vec_t;

    vec_t tbl[10];
    logic [W-1:0] b2b_words[3];
    logic [W-1:0] cur;
    int k, c0, run, gap, n;
    int acc_at[3];
    logic vrec[30];
    logic lrec[30];

    initial begin
        data_valid = 1'b0; data_in = '0;
        lsb_data_valid = 1'b0; lsb_data_in = '0;

        // Reset values, effective immediately
        #3 rst_n = 1'b0;
        #1;
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_d", d_out, 1'b0);
        chk("rst_last", last_out, 1'b0);
        chk("rst_ready", data_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_ready = 1'b1;
        #1 chk("ready_after_rst", data_ready, 1'b1);

        // Single word 0xA5 from idle, table driven
        tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].dv, tbl[i].din);
            chk("tbl_valid", valid_out, tbl[i].ev);
            chk("tbl_d", d_out, tbl[i].ed);
            chk("tbl_last", last_out, tbl[i].el);
            chk("tbl_ready", data_ready, tbl[i].er);
        end

        // Back-to-back 0x3C, 0xFF, 0x01 with data_valid held high
        b2b_words[0] = 8'h3C; b2b_words[1] = 8'hFF; b2b_words[2] = 8'h01;
        k = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(k < 3, (k < 3) ? b2b_words[k] : 8'h00);
            if (last_acc) begin
                acc_at[k] = i;
                k++;
            end
            vrec[i] = valid_out;
            lrec[i] = last_out;
        end
        chk_int("b2b_accepts", k, 3);
        c0 = acc_at[0];
        chk_int("b2b_second_accept", acc_at[1] - c0, 1);
        chk_int("b2b_third_accept", acc_at[2] - c0, 9);
        run = 0;
        for (int i = c0; i < 30 && vrec[i]; i++) run++;
        chk_int("b2b_valid_run", run, 24);
        for (int i = 0; i < 24 && c0 + i < 30; i++)
            chk("b2b_last_pos", lrec[c0+i], (i == 7) || (i == 15) || (i == 23));

        // LSB-first instance: 0x01 -> 1,0,0,0,0,0,0,0
        @(negedge clk);
        lsb_data_valid = 1'b1; lsb_data_in = 8'h01;
        chk("lsb_ready", lsb_data_ready, 1'b1);
        @(negedge clk);
        lsb_data_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            chk("lsb_valid", lsb_valid_out, 1'b1);
            chk("lsb_d", lsb_d_out, i == 0);
            chk("lsb_last", lsb_last_out, i == W - 1);
            @(negedge clk);
        end
        chk("lsb_idle", lsb_valid_out, 1'b0);

        // Reset mid-word: 0xF0 shifting, 0xAA buffered, reset after the 3rd bit
        cycle(1'b1, 8'hF0);
        cycle(1'b1, 8'hAA);
        chk("rmw_buffered", data_ready, 1'b0);
        cycle(1'b0, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("rmw_valid", valid_out, 1'b0);
        chk("rmw_d", d_out, 1'b0);
        chk("rmw_last", last_out, 1'b0);
        chk("rmw_ready", data_ready, 1'b0);
        exp_q.delete();
        last_q.delete();
        model_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_ready = 1'b1;
        repeat (12) cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h81);
        repeat (10) cycle(1'b0, 8'h00);

        // Stall / gap: 3 idle edges between two words
        cycle(1'b1, 8'h5A);
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 8'h00);
            if (!valid_out) gap++;
        end
        chk_int("gap_idle_cycles", gap, 3);
        cycle(1'b1, 8'hC3);
        chk("gap_restart", valid_out, 1'b1);
        repeat (10) cycle(1'b0, 8'h00);

        // Random stream: 540 words, source holds each word until accepted
        n = 0;
        cur = W'($urandom);
        for (int cyc = 0; cyc < 20000 && n < 540; cyc++) begin
            cycle($urandom_range(0, 9) < 8, cur);
            if (last_acc) begin
                n++;
                cur = W'($urandom);
            end
        end
        chk_int("rand_words", n, 540);
        repeat (20) cycle(1'b0, 8'h00);
        chk_int("rand_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
